ldpc_frame_arb: RTL and testbench
=================================

// Module: ldpc_frame_arb
// PURPOSE
//  Shares the single LDPC decoder between two soft-bit frame sources (SRC0/SRC1 de-interleaver buffers).
//  Round-robin grants whole codewords, latches each frame's rate, streams 6-bit LLRs into the decoder on its ldpc_req.
//  Tags every decoded output frame with its source id.
//  Sits between the de-interleavers and ldpc_decoder (drives bidin_rdy/en_in/din/rate, observes ldpc_req/sync_out/busy).
// PARAMETERS
//  FRAME_LEN   9216  LLR samples per codeword (both rates)
//  DW          6     soft-bit width
//  TMO_CYC     65535 max cycles waiting for dec_ldpc_req before timeout
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous active-low reset
//  src_rdy       in   2   [i]=1: source i holds a complete frame
//  src_rate      in   2   [i]=code rate of source i's frame (0=1/2, 1=3/4)
//  src_rd        out  2   [i]=read strobe; source returns data 1 cycle later
//  src_din0      in   DW  source 0 LLR, valid cycle after src_rd[0]
//  src_din1      in   DW  source 1 LLR, valid cycle after src_rd[1]
//  src_done      out  2   [i]=1-cycle pulse: frame from source i fully read
//  dec_bidin_rdy out  1   frame available to decoder
//  dec_ldpc_req  in   1   decoder pulse: ready to accept a frame
//  dec_rate      out  1   rate of frame being loaded, stable until next grant
//  dec_en_in     out  1   LLR valid to decoder
//  dec_din       out  DW  LLR to decoder
//  dec_sync_out  in   1   decoder first-bit-of-frame pulse on output
//  out_src_id    out  1   source id of frame currently on decoder output
//  out_id_vld    out  1   out_src_id valid (set at sync_out, held until next)
//  tmo_err       out  1   1-cycle pulse on request timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_last=1 (SRC0 wins first tie); counters, tag FIFO cleared.
//  FSM IDLE: if |src_rdy and tag FIFO not full -> pick winner, latch rate/id, go WAIT.
//   Winner: only one ready -> that one; both -> the one != rr_last.
//  WAIT: dec_bidin_rdy=1; on dec_ldpc_req -> LOAD, clear cnt.
//   cnt_tmo>=TMO_CYC -> tmo_err pulse, drop grant, rr_last unchanged, -> IDLE.
//  LOAD: src_rd[id]=1 for exactly FRAME_LEN consecutive cycles; dec_bidin_rdy=0.
//   Last read (cnt==FRAME_LEN-1) -> src_done[id] pulse same cycle, push id to tag FIFO, rr_last<=id, -> IDLE.
//  Datapath: src_rd at t -> src_dinX at t+1 -> registered dec_din/dec_en_in at t+2; total latency 2 cycles.
//   dec_en_in is src_rd delayed 2; dec_din muxed by latched id; dec_din=0 when dec_en_in=0.
//   Earliest next grant: cycle after last read; pipeline tail overlaps IDLE/WAIT; no bubble required.
//  src_rdy sampled only in IDLE; deassertion during LOAD ignored (source owns frame until src_done).
//  dec_ldpc_req outside WAIT ignored.
//  Tag FIFO, depth 2 (one frame decoding, one loaded).
//   Pop on dec_sync_out -> out_src_id<=head, out_id_vld<=1.
//   sync_out with FIFO empty: out_id_vld<=0, no pop. Simultaneous push+pop allowed; full blocks IDLE grant.
//  cnt: 14-bit, counts 0..FRAME_LEN-1, no wrap; cnt_tmo: 16-bit saturating, cleared on entering WAIT.
//  Async reset mid-LOAD: src_rd drops immediately; partial frame abandoned; source must re-present.
// STRUCTURE
//  ldpc_pkg: FRAME_LEN, DW, state encoding (IDLE/WAIT/LOAD), RATE_12/RATE_34 constants.
//  Sub-module ldpc_tag_fifo (2-deep, 1-bit, push/pop/full/empty); FSM, counters, data mux in top.
// TESTING
//  Only SRC0 ready, rate 1, req 5 cyc after bidin_rdy -> 9216 src_rd[0], dec_en_in 9216 cyc lagging 2; dec_rate=1; src_done[0] once.
//  Both ready from reset -> grant order 0,1,0,1 over 4 frames; dec_din matches each source's ramp pattern.
//  No ldpc_req, TMO_CYC=100 -> tmo_err pulse at cycle 100 of WAIT; next grant same source; no src_rd issued.
//  Two frames loaded, sync_out x2 -> out_src_id 0 then 1, out_id_vld=1; third sync_out -> out_id_vld=0.
//  FIFO full (no sync_out) with src_rdy=11 -> no third grant until sync_out pops; grant within 2 cycles after.
//  reset_n low at LOAD cnt=4000 -> all outputs 0 async; after release SRC0 granted again, full 9216 reads.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC decoder front-end arbiter.
package ldpc_pkg;

    localparam int unsigned FRAME_LEN   = 9216;
    localparam int unsigned DW          = 6;
    localparam int unsigned TMO_CYC_DEF = 65535;
    localparam int unsigned CNT_W       = 14;
    localparam int unsigned TMO_W       = 16;

    localparam logic RATE_12 = 1'b0;
    localparam logic RATE_34 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ldpc_tag_fifo.sv
// Two-entry, one-bit FIFO carrying the source id of each frame handed to the decoder.
module ldpc_tag_fifo (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  logic push_id_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    logic [1:0] mem_q, mem_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == 2'd0);
        full_o  = (cnt_q == 2'd2);
        do_pop  = pop_i && !empty_o;
        // a pop in the same cycle frees the slot the push needs
        do_push = push_i && (!full_o || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_id_i;
            wr_d        = ~wr_q;
        end
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign head_o = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
            cnt_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/ldpc_frame_arb.sv
// Round-robin arbiter sharing one LDPC decoder between two soft-bit frame sources.
//  state | meaning
//  IDLE  | waiting for a ready source and a free tag slot
//  WAIT  | frame offered (bidin_rdy), waiting for decoder request or timeout
//  LOAD  | streaming FRAME_LEN LLRs from the granted source
module ldpc_frame_arb
    import ldpc_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic [1:0]    src_rdy_i,
    input  logic [1:0]    src_rate_i,
    output logic [1:0]    src_rd_o,
    input  logic [DW-1:0] src_din0_i,
    input  logic [DW-1:0] src_din1_i,
    output logic [1:0]    src_done_o,
    output logic          dec_bidin_rdy_o,
    input  logic          dec_ldpc_req_i,
    output logic          dec_rate_o,
    output logic          dec_en_in_o,
    output logic [DW-1:0] dec_din_o,
    input  logic          dec_sync_out_i,
    output logic          out_src_id_o,
    output logic          out_id_vld_o,
    output logic          tmo_err_o
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             id_q, id_d;
    logic             rate_q, rate_d;
    logic             rr_last_q, rr_last_d;
    logic             rd_p1_q, en_q;
    logic [DW-1:0]    din_q;
    logic             out_id_q, out_vld_q;
    logic             tag_push, tag_head, tag_full, tag_empty;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        id_d            = id_q;
        rate_d          = rate_q;
        rr_last_d       = rr_last_q;
        src_rd_o        = 2'b00;
        src_done_o      = 2'b00;
        dec_bidin_rdy_o = 1'b0;
        tmo_err_o       = 1'b0;
        tag_push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|src_rdy_i && !tag_full) begin
                    id_d    = (&src_rdy_i) ? ~rr_last_q : src_rdy_i[1];
                    rate_d  = src_rate_i[id_d];
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dec_bidin_rdy_o = 1'b1;
                if (dec_ldpc_req_i) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else if (tmo_q >= TMO_W'(TMO_CYC)) begin
                    // grant dropped without touching rr_last: same source wins again
                    tmo_err_o = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOAD: begin
                src_rd_o = onehot2(id_q);
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    src_done_o = onehot2(id_q);
                    tag_push   = 1'b1;
                    rr_last_d  = id_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            id_q      <= 1'b0;
            rate_q    <= RATE_12;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            id_q      <= id_d;
            rate_q    <= rate_d;
            rr_last_q <= rr_last_d;
        end
    end

    // id_q only changes at the end of the IDLE cycle, after the tail sample is muxed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_p1_q <= 1'b0;
            en_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            rd_p1_q <= |src_rd_o;
            en_q    <= rd_p1_q;
            din_q   <= rd_p1_q ? (id_q ? src_din1_i : src_din0_i) : '0;
        end
    end

    ldpc_tag_fifo u_tag_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (reset_n_i),
        .push_i    (tag_push),
        .push_id_i (id_q),
        .pop_i     (dec_sync_out_i),
        .head_o    (tag_head),
        .full_o    (tag_full),
        .empty_o   (tag_empty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_id_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (dec_sync_out_i) begin
            if (!tag_empty) begin
                out_id_q  <= tag_head;
                out_vld_q <= 1'b1;
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign dec_rate_o   = rate_q;
    assign dec_en_in_o  = en_q;
    assign dec_din_o    = din_q;
    assign out_src_id_o = out_id_q;
    assign out_id_vld_o = out_vld_q;

endmodule

// File: tb/tb_ldpc_frame_arb.sv
// Directed bench for ldpc_frame_arb: single source, round-robin with tag FIFO, timeout, async reset.
module tb_ldpc_frame_arb;
    import ldpc_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    src_rdy, src_rate, src_rd, src_done;
    logic [DW-1:0] din0, din1, dec_din;
    logic          bidin, req, rate, en, sync, oid, ovld, tmo;
    wire  [15:0]   outs = {src_rd, src_done, bidin, rate, en, dec_din, oid, ovld, tmo};

    always #5 clk = ~clk;

    ldpc_frame_arb #(.TMO_CYC(100)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .src_rdy_i       (src_rdy),
        .src_rate_i      (src_rate),
        .src_rd_o        (src_rd),
        .src_din0_i      (din0),
        .src_din1_i      (din1),
        .src_done_o      (src_done),
        .dec_bidin_rdy_o (bidin),
        .dec_ldpc_req_i  (req),
        .dec_rate_o      (rate),
        .dec_en_in_o     (en),
        .dec_din_o       (dec_din),
        .dec_sync_out_i  (sync),
        .out_src_id_o    (oid),
        .out_id_vld_o    (ovld),
        .tmo_err_o       (tmo)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pat(input logic s, input int k);
        int v;
        v = s ? (k * 3 + 17) : k;
        return v[5:0];
    endfunction

    // source buffers: data for a read strobe appears the following cycle
    int k0, k1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k0 <= 0; k1 <= 0; din0 <= '0; din1 <= '0;
        end else begin
            if (src_rd[0]) begin din0 <= pat(1'b0, k0); k0 <= src_done[0] ? 0 : k0 + 1; end
            if (src_rd[1]) begin din1 <= pat(1'b1, k1); k1 <= src_done[1] ? 0 : k1 + 1; end
        end
    end

    int   rd_cnt[2], done_cnt[2], glog[8];
    int   en_cnt, data_err, zero_err, lag_err, en_k, fidx, nlog;
    int   exp_order[4] = '{0, 1, 0, 1};
    logic [1:0] rd_hist;
    logic prev_rd;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_cnt = '{0, 0}; done_cnt = '{0, 0};
                en_cnt = 0; data_err = 0; zero_err = 0; lag_err = 0;
                en_k = 0; fidx = 0; nlog = 0; rd_hist = 2'b00; prev_rd = 1'b0;
            end else begin
                if (en !== rd_hist[1]) lag_err++;
                rd_hist = {rd_hist[0], |src_rd};
                if (src_rd[0]) rd_cnt[0]++;
                if (src_rd[1]) rd_cnt[1]++;
                if (|src_rd && !prev_rd && nlog < 8) begin
                    glog[nlog] = int'(src_rd[1]);
                    nlog++;
                end
                prev_rd = |src_rd;
                if (src_done[0]) done_cnt[0]++;
                if (src_done[1]) done_cnt[1]++;
                if (en === 1'b1) begin
                    if (dec_din !== pat(exp_order[fidx % 4] != 0, en_k)) data_err++;
                    en_cnt++;
                    en_k++;
                    if (en_k == int'(FRAME_LEN)) begin en_k = 0; fidx++; end
                end else if (dec_din !== '0) begin
                    zero_err++;
                end
            end
        end
    end

    task automatic do_reset(input logic [1:0] rdy, input logic [1:0] rate_v);
        reset_n = 1'b0; req = 1'b0; sync = 1'b0; src_rdy = rdy; src_rate = rate_v;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_bidin(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bidin === 1'b1) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
    endtask

    task automatic pulse_sync();
        @(posedge clk); #1 sync = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
    endtask

    task automatic load_frame(input string tag, input logic s);
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk({tag, "_rd_start"}, src_rd, s ? 2 : 1);
        for (int n = 0; n < 9400; n++) begin
            if (src_done !== 2'b00) break;
            @(negedge clk);
        end
        chk({tag, "_done"}, src_done, s ? 2 : 1);
    endtask

    initial begin
        int blk, n_tmo, rdn, rds;
        reset_n = 1'b0; req = 1'b0; sync = 1'b0; src_rdy = 2'b00; src_rate = 2'b00;

        // single source, rate 3/4, late request
        src_rdy = 2'b01; src_rate = {RATE_12, RATE_34};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", outs, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        wait_bidin("s1_grant");
        repeat (4) @(posedge clk);
        load_frame("s1", 1'b0);
        @(posedge clk); #1 src_rdy = 2'b00;
        repeat (5) @(negedge clk);
        chk("s1_rd0", rd_cnt[0], 9216);
        chk("s1_rd1", rd_cnt[1], 0);
        chk("s1_en", en_cnt, 9216);
        chk("s1_done0", done_cnt[0], 1);
        chk("s1_lag", lag_err, 0);
        chk("s1_data", data_err, 0);
        chk("s1_zero", zero_err, 0);
        chk("s1_rate", rate, 1);
        chk("s1_idle", bidin, 0);

        // both ready: round robin, tag FIFO full blocking, tag order
        do_reset(2'b11, {RATE_34, RATE_12});
        wait_bidin("s2_g0");
        chk("s2_rate0", rate, 0);
        load_frame("s2_f0", 1'b0);
        wait_bidin("s2_g1");
        chk("s2_rate1", rate, 1);
        load_frame("s2_f1", 1'b1);
        blk = 0;
        repeat (20) begin
            @(negedge clk);
            if (bidin !== 1'b0 || src_rd !== 2'b00) blk++;
        end
        chk("s2_full_block", blk, 0);
        pulse_sync();
        @(negedge clk);
        chk("s2_tag0_id", oid, 0);
        chk("s2_tag0_vld", ovld, 1);
        chk("s2_pop_idle", bidin, 0);
        @(negedge clk);
        chk("s2_regrant", bidin, 1);
        chk("s2_rate2", rate, 0);
        pulse_sync();
        @(negedge clk);
        chk("s2_tag1_id", oid, 1);
        chk("s2_tag1_vld", ovld, 1);
        fork
            load_frame("s2_f2", 1'b0);
            begin
                repeat (20) @(posedge clk);
                #1 sync = 1'b1;
                @(posedge clk); #1 sync = 1'b0;
                @(negedge clk);
                chk("s2_vld_empty", ovld, 0);
            end
        join
        wait_bidin("s2_g3");
        chk("s2_rate3", rate, 1);
        load_frame("s2_f3", 1'b1);
        repeat (5) @(negedge clk);
        chk("s2_nlog", nlog, 4);
        chk("s2_order0", glog[0], 0);
        chk("s2_order1", glog[1], 1);
        chk("s2_order2", glog[2], 0);
        chk("s2_order3", glog[3], 1);
        chk("s2_rd0", rd_cnt[0], 18432);
        chk("s2_rd1", rd_cnt[1], 18432);
        chk("s2_en", en_cnt, 36864);
        chk("s2_done0", done_cnt[0], 2);
        chk("s2_done1", done_cnt[1], 2);
        chk("s2_data", data_err, 0);
        chk("s2_lag", lag_err, 0);
        chk("s2_zero", zero_err, 0);

        // request timeout, regrant to same source
        do_reset(2'b11, {RATE_34, RATE_12});
        wait_bidin("s3_grant");
        n_tmo = -1; rdn = 0;
        for (int n = 0; n <= 300; n++) begin
            if (n > 0) @(negedge clk);
            if (src_rd !== 2'b00) rdn++;
            if (tmo === 1'b1) begin n_tmo = n; break; end
        end
        chk("s3_tmo_cyc", n_tmo, 100);
        chk("s3_no_rd", rdn, 0);
        @(negedge clk);
        chk("s3_tmo_pulse", tmo, 0);
        chk("s3_idle", bidin, 0);
        @(negedge clk);
        chk("s3_regrant", bidin, 1);
        chk("s3_same_rate", rate, 0);
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("s3_rd_src0", src_rd, 1);

        // async reset in the middle of a load
        do_reset(2'b01, {RATE_12, RATE_34});
        wait_bidin("s4_grant");
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        rds = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (src_rd[0] === 1'b1) rds++;
            if (rds == 4001) break;
        end
        chk("s4_reach", rds, 4001);
        #2 reset_n = 1'b0;
        #1 chk("s4_async_clr", outs, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_bidin("s4_regrant");
        load_frame("s4_f", 1'b0);
        @(posedge clk); #1 src_rdy = 2'b00;
        repeat (5) @(negedge clk);
        chk("s4_rd0", rd_cnt[0], 9216);
        chk("s4_en", en_cnt, 9216);
        chk("s4_done0", done_cnt[0], 1);
        chk("s4_order", glog[0], 0);
        chk("s4_data", data_err, 0);
        chk("s4_lag", lag_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
